// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: one write port, two registered read ports, sticky error flag.
interface reg_file_2r1w_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;
  logic              rvalid_a;
  logic              rvalid_b;
  logic              err_clr;
  logic              err;

  modport master (
    output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, err_clr,
    input  rdata_a, rdata_b, rvalid_a, rvalid_b, err
  );

  modport slave (
    input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, err_clr,
    output rdata_a, rdata_b, rvalid_a, rvalid_b, err
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write register file with registered reads, write bypass and sticky range error.
// Optional macro ZERO_REG_EN makes entry 0 a hardwired zero.
module reg_file_2r1w #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  reg_file_2r1w_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             rvalid_a_q, rvalid_a_d;
  logic             rvalid_b_q, rvalid_b_d;
  logic             err_q, err_d;

  logic wr_oob, rd_oob_a, rd_oob_b;
  logic wr_zero, rd_zero_a, rd_zero_b;
  logic wr_ok, new_err;

  always_comb begin
    wr_oob    = bus.we   && ({1'b0, bus.waddr}   >= DEPTH_L);
    rd_oob_a  = bus.re_a && ({1'b0, bus.raddr_a} >= DEPTH_L);
    rd_oob_b  = bus.re_b && ({1'b0, bus.raddr_b} >= DEPTH_L);
    wr_zero   = ZERO_REG && (bus.waddr   == '0);
    rd_zero_a = ZERO_REG && (bus.raddr_a == '0);
    rd_zero_b = ZERO_REG && (bus.raddr_b == '0);
    // Dropped zero-register writes also disable bypass on address 0.
    wr_ok     = bus.we && !wr_oob && !wr_zero;
    new_err   = wr_oob || rd_oob_a || rd_oob_b;
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[bus.waddr] = bus.wdata;

    rdata_a_d  = rdata_a_q;
    rvalid_a_d = bus.re_a;
    if (bus.re_a) begin
      if (rd_oob_a || rd_zero_a)                  rdata_a_d = '0;
      else if (wr_ok && bus.waddr == bus.raddr_a) rdata_a_d = bus.wdata;
      else                                        rdata_a_d = mem_q[bus.raddr_a];
    end

    rdata_b_d  = rdata_b_q;
    rvalid_b_d = bus.re_b;
    if (bus.re_b) begin
      if (rd_oob_b || rd_zero_b)                  rdata_b_d = '0;
      else if (wr_ok && bus.waddr == bus.raddr_b) rdata_b_d = bus.wdata;
      else                                        rdata_b_d = mem_q[bus.raddr_b];
    end

    // A new error wins over a same-cycle clear.
    if (new_err)          err_d = 1'b1;
    else if (bus.err_clr) err_d = 1'b0;
    else                  err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      err_q      <= err_d;
    end
  end

  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.err      = err_q;

endmodule
